weather_response_sequencer: RTL and testbench

//  Downstream consumer of the environmental surveillance unit outputs (severe_weather,

---
 rtl/weather_response_sequencer.sv | 179 +++++++++++++++++
 tb/tb_weather_response_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/weather_response_sequencer.sv
// Turns the ECSU weather picture into launch/recall/landing actions and flags illegal ECSU jumps.
// Define ACK_TIMEOUT_EN to add the LAND_REQ wait counter and the sticky land_timeout flag.
module weather_response_sequencer #(
  parameter int CAUTION_LIMIT = 16,
  parameter int RELEASE_CYC   = 8,
  parameter int RECALL_CYC    = 10,
  parameter int ACK_TIMEOUT   = 32,
  parameter int CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             severe_weather,
  input  logic             emergency_landing_alert,
  input  logic [1:0]       ECSU_state,
  input  logic             land_ack,
  output logic             launch_inhibit,
  output logic             recall_req,
  output logic             land_req,
  output logic [CNT_W-1:0] land_countdown,
  output logic [2:0]       seq_state,
  output logic             protocol_error,
  output logic             land_timeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WATCH    = 3'b001,
    HOLD     = 3'b010,
    RECALL   = 3'b011,
    LAND_REQ = 3'b100,
    LANDED   = 3'b101
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ecsu_q, ecsu_d, prev_q, prev_d;
  logic             alert_q, alert_d, ack_q, ack_d, severe_q, severe_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, countdown_q, countdown_d, dwell_sat;
  logic             launch_inhibit_q, launch_inhibit_d;
  logic             recall_req_q, recall_req_d;
  logic             land_req_q, land_req_d;
  logic             protocol_error_q, protocol_error_d;
  logic             emerg;
`ifdef ACK_TIMEOUT_EN
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             land_timeout_q, land_timeout_d;
`endif

  function automatic logic ecsu_legal(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101, 4'b0110,
      4'b1001, 4'b1010, 4'b1011,
      4'b1111: ecsu_legal = 1'b1;
      default: ecsu_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    ecsu_d           = ECSU_state;
    alert_d          = emergency_landing_alert;
    ack_d            = land_ack;
    severe_d         = severe_weather;
    prev_d           = ecsu_q;
    state_d          = state_q;
    dwell_d          = dwell_q;
    countdown_d      = countdown_q;
    protocol_error_d = protocol_error_q | ~ecsu_legal(prev_q, ecsu_q);
    emerg            = (ecsu_q == 2'b11) | alert_q;
    dwell_sat        = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (emerg)                  state_d = RECALL;
        else if (ecsu_q == 2'b01)   state_d = WATCH;
        else if (ecsu_q == 2'b10)   state_d = HOLD;
      end
      WATCH: begin
        if (emerg)                  state_d = RECALL;
        else if (ecsu_q == 2'b00)   state_d = IDLE;
        else if (ecsu_q == 2'b10)   state_d = HOLD;
        else if (dwell_q == CNT_W'(CAUTION_LIMIT - 1)) state_d = HOLD;
        else                        dwell_d = dwell_sat;
      end
      HOLD: begin
        // Only an unbroken run of CAUTION releases the hold; anything else restarts it.
        if (emerg)                  state_d = RECALL;
        else if (ecsu_q == 2'b01) begin
          if (dwell_q == CNT_W'(RELEASE_CYC - 1)) state_d = WATCH;
          else                                    dwell_d = dwell_sat;
        end
        else                        dwell_d = '0;
      end
      RECALL: begin
        if (countdown_q == '0)      state_d = LAND_REQ;
        else                        countdown_d = countdown_q - CNT_W'(1);
      end
      LAND_REQ: begin
        if (ack_q)                  state_d = LANDED;
      end
      LANDED:                       state_d = LANDED;
      default:                      state_d = IDLE;
    endcase

    if (state_d != state_q) dwell_d = '0;
    if (state_d == RECALL && state_q != RECALL) countdown_d = CNT_W'(RECALL_CYC - 1);
    else if (state_d != RECALL)                 countdown_d = '0;

    launch_inhibit_d = state_d inside {HOLD, RECALL, LAND_REQ, LANDED};
    recall_req_d     = state_d inside {RECALL, LAND_REQ};
    land_req_d       = (state_d == LAND_REQ);

`ifdef ACK_TIMEOUT_EN
    wait_d         = wait_q;
    land_timeout_d = land_timeout_q;
    if (state_q == LAND_REQ && !ack_q) begin
      if (wait_q == CNT_W'(ACK_TIMEOUT - 1)) land_timeout_d = 1'b1;
      if (wait_q != '1)                      wait_d = wait_q + CNT_W'(1);
    end
    if (state_d == LAND_REQ && state_q != LAND_REQ) wait_d = '0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q          <= IDLE;
      ecsu_q           <= 2'b00;
      prev_q           <= 2'b00;
      alert_q          <= 1'b0;
      ack_q            <= 1'b0;
      severe_q         <= 1'b0;
      dwell_q          <= '0;
      countdown_q      <= '0;
      launch_inhibit_q <= 1'b0;
      recall_req_q     <= 1'b0;
      land_req_q       <= 1'b0;
      protocol_error_q <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      wait_q           <= '0;
      land_timeout_q   <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      ecsu_q           <= ecsu_d;
      prev_q           <= prev_d;
      alert_q          <= alert_d;
      ack_q            <= ack_d;
      severe_q         <= severe_d;
      dwell_q          <= dwell_d;
      countdown_q      <= countdown_d;
      launch_inhibit_q <= launch_inhibit_d;
      recall_req_q     <= recall_req_d;
      land_req_q       <= land_req_d;
      protocol_error_q <= protocol_error_d;
`ifdef ACK_TIMEOUT_EN
      wait_q           <= wait_d;
      land_timeout_q   <= land_timeout_d;
`endif
    end
  end

  assign launch_inhibit = launch_inhibit_q;
  assign recall_req     = recall_req_q;
  assign land_req       = land_req_q;
  assign land_countdown = countdown_q;
  assign seq_state      = state_q;
  assign protocol_error = protocol_error_q;

  // severe_weather is captured for observation only and deliberately steers nothing.
`ifdef ACK_TIMEOUT_EN
  logic unused_ok;
  assign unused_ok    = severe_q;
  assign land_timeout = land_timeout_q;
`else
  logic [32:0] unused_ok;
  assign unused_ok    = {severe_q, 32'(ACK_TIMEOUT)};
  assign land_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_weather_response_sequencer.sv
// Randomised bench for weather_response_sequencer: every cycle the outputs are compared
// against a run-length/time-count model of the sequencer rules.
module tb_weather_response_sequencer;

  localparam int CAUTION_LIMIT = 16;
  localparam int RELEASE_CYC   = 8;
  localparam int RECALL_CYC    = 10;
  localparam int ACK_TIMEOUT   = 32;
  localparam int CNT_W         = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             severe_weather = 1'b0;
  logic             emergency_landing_alert = 1'b0;
  logic [1:0]       ECSU_state = 2'b00;
  logic             land_ack = 1'b0;
  logic             launch_inhibit, recall_req, land_req, protocol_error, land_timeout;
  logic [CNT_W-1:0] land_countdown;
  logic [2:0]       seq_state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase number, run lengths and elapsed-time counters.
  int mPhase, mRun, mRecallCyc, mWait, mEcsu, mPrev;
  bit mAlert, mAck, mErr, mTimeout;
  bit [15:0] legalPairs = 16'h8E77;

  weather_response_sequencer #(
    .CAUTION_LIMIT(CAUTION_LIMIT), .RELEASE_CYC(RELEASE_CYC), .RECALL_CYC(RECALL_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .severe_weather(severe_weather),
    .emergency_landing_alert(emergency_landing_alert), .ECSU_state(ECSU_state),
    .land_ack(land_ack), .launch_inhibit(launch_inhibit), .recall_req(recall_req),
    .land_req(land_req), .land_countdown(land_countdown), .seq_state(seq_state),
    .protocol_error(protocol_error), .land_timeout(land_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic modelStep();
    int nxt;
    bit emerg;
    if (RST) begin
      mPhase = 0; mRun = 0; mRecallCyc = 0; mWait = 0; mEcsu = 0; mPrev = 0;
      mAlert = 0; mAck = 0; mErr = 0; mTimeout = 0;
      return;
    end
    if (!legalPairs[mPrev*4 + mEcsu]) mErr = 1;
    emerg = (mEcsu == 3) || mAlert;
    nxt   = mPhase;
    case (mPhase)
      0: if (emerg) nxt = 3; else if (mEcsu == 1) nxt = 1; else if (mEcsu == 2) nxt = 2;
      1: begin
        if (emerg) nxt = 3;
        else if (mEcsu == 0) nxt = 0;
        else if (mEcsu == 2) nxt = 2;
        else begin
          mRun++;
          if (mRun >= CAUTION_LIMIT) nxt = 2;
        end
      end
      2: begin
        if (emerg) nxt = 3;
        else if (mEcsu == 1) begin
          mRun++;
          if (mRun >= RELEASE_CYC) nxt = 1;
        end
        else mRun = 0;
      end
      3: begin
        mRecallCyc++;
        if (mRecallCyc >= RECALL_CYC) nxt = 4;
      end
      4: begin
        if (mAck) nxt = 5;
        else begin
          mWait++;
          if (mWait == ACK_TIMEOUT) mTimeout = 1;
        end
      end
      default: nxt = mPhase;
    endcase
    if (nxt != mPhase) begin
      mRun = 0; mRecallCyc = 0; mWait = 0;
    end
    mPhase = nxt;
    mPrev  = mEcsu;
    mEcsu  = ECSU_state;
    mAlert = emergency_landing_alert;
    mAck   = land_ack;
  endtask

  task automatic checkAll();
    int expCount;
    bit expTimeout;
    expCount = (mPhase == 3) ? (RECALL_CYC - 1 - mRecallCyc) : 0;
`ifdef ACK_TIMEOUT_EN
    expTimeout = mTimeout;
`else
    expTimeout = 1'b0;
`endif
    checkOutput("seq_state", 32'(seq_state), 32'(mPhase));
    checkOutput("launch_inhibit", 32'(launch_inhibit), 32'(mPhase >= 2));
    checkOutput("recall_req", 32'(recall_req), 32'(mPhase == 3 || mPhase == 4));
    checkOutput("land_req", 32'(land_req), 32'(mPhase == 4));
    checkOutput("land_countdown", 32'(land_countdown), 32'(expCount));
    checkOutput("protocol_error", 32'(protocol_error), 32'(mErr));
    checkOutput("land_timeout", 32'(land_timeout), 32'(expTimeout));
  endtask

  task automatic applyStimulus(input logic [1:0] ecsu, input logic alert, input logic ack,
                               input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      ECSU_state              = ecsu;
      emergency_landing_alert = alert;
      land_ack                = ack;
      RST                     = rst;
      severe_weather          = 1'($urandom_range(0, 1));
      @(posedge CLK);
      modelStep();
      @(negedge CLK);
      checkAll();
    end
  endtask

  function automatic logic [1:0] pickLegal(input logic [1:0] cur);
    int r;
    r = $urandom_range(0, 2);
    case (cur)
      2'b00, 2'b01: pickLegal = 2'(r);
      2'b10:        pickLegal = 2'(r + 1);
      default:      pickLegal = 2'b11;
    endcase
  endfunction

  initial begin
    logic [1:0] cur;
    int ackRange;

    // Reset and quiet CLEAR period.
    applyStimulus(2'b00, 0, 0, 1, 2);
    applyStimulus(2'b00, 0, 0, 0, 20);
    // CAUTION escalation WATCH -> HOLD, then interrupted and unbroken release runs.
    applyStimulus(2'b01, 0, 0, 0, 18);
    applyStimulus(2'b10, 0, 0, 0, 3);
    applyStimulus(2'b01, 0, 0, 0, 7);
    applyStimulus(2'b10, 0, 0, 0, 1);
    applyStimulus(2'b01, 0, 0, 0, 12);
    // HIGH -> EMERG, recall countdown, landing handshake, then CLEAR while landed.
    applyStimulus(2'b10, 0, 0, 0, 3);
    applyStimulus(2'b11, 0, 0, 0, 15);
    applyStimulus(2'b11, 0, 1, 0, 4);
    applyStimulus(2'b00, 0, 0, 0, 5);
    // Illegal jumps 00->11 and 10->00.
    applyStimulus(2'b00, 0, 0, 1, 1);
    applyStimulus(2'b00, 0, 0, 0, 3);
    applyStimulus(2'b11, 0, 0, 0, 3);
    applyStimulus(2'b00, 0, 0, 1, 1);
    applyStimulus(2'b10, 0, 0, 0, 3);
    applyStimulus(2'b00, 0, 0, 0, 4);
    // Alert-driven recall, reset mid-handshake, stray ack in IDLE.
    applyStimulus(2'b00, 0, 0, 1, 1);
    applyStimulus(2'b00, 1, 0, 0, 2);
    applyStimulus(2'b00, 0, 0, 0, 15);
    applyStimulus(2'b00, 0, 0, 1, 1);
    applyStimulus(2'b00, 0, 1, 0, 5);
    // Long wait in LAND_REQ without acknowledge.
    applyStimulus(2'b00, 0, 0, 1, 1);
    applyStimulus(2'b00, 1, 0, 0, 1);
    applyStimulus(2'b00, 0, 0, 0, 50);

    // Random walks, mostly legal ECSU moves with occasional illegal jumps and resets.
    for (int ep = 0; ep < 8; ep++) begin
      applyStimulus(2'b00, 0, 0, 1, 2);
      cur      = 2'b00;
      ackRange = (ep % 2 == 1) ? 63 : 5;
      for (int c = 0; c < 400; c++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)     cur = 2'($urandom_range(0, 3));
        else if (r < 4) cur = pickLegal(cur);
        applyStimulus(cur, 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, ackRange) == 0),
                      1'($urandom_range(0, 249) == 0), 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
